// File: rtl/io_bus_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : io_bus_responder                                         |
// | Description : Memory-mapped I/O responder on the CPU data bus. Serves  |
// |               debounced switches, LEDs, a scanned 8-digit 7-segment    |
// |               display and an optional cycle timer.                     |
// | Options     : define IO_TIMER_EN to build the cycle timer at 0x020.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module io_bus_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000,
  parameter int          SCAN_DIV   = 50_000,
  parameter int          DEB_CYCLES = 100_000,
  parameter int          TIMER_DIV  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        hit_o,
  input  logic [23:0] sw_i,
  output logic [23:0] led_o,
  output logic [7:0]  seg_an_o,
  output logic [7:0]  seg_ca_o
);

  // Word offsets within the 4 KiB window (addr_i[11:2])
  localparam logic [9:0] C_OFF_DISP  = 10'h000;
  localparam logic [9:0] C_OFF_TIMER = 10'h008;
  localparam logic [9:0] C_OFF_LED   = 10'h018;
  localparam logic [9:0] C_OFF_SW    = 10'h01C;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] C_SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  C_DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  // Hex digit to active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 8'hC0;
      4'h1: hex_glyph = 8'hF9;
      4'h2: hex_glyph = 8'hA4;
      4'h3: hex_glyph = 8'hB0;
      4'h4: hex_glyph = 8'h99;
      4'h5: hex_glyph = 8'h92;
      4'h6: hex_glyph = 8'h82;
      4'h7: hex_glyph = 8'hF8;
      4'h8: hex_glyph = 8'h80;
      4'h9: hex_glyph = 8'h90;
      4'hA: hex_glyph = 8'h88;
      4'hB: hex_glyph = 8'h83;
      4'hC: hex_glyph = 8'hC6;
      4'hD: hex_glyph = 8'hA1;
      4'hE: hex_glyph = 8'h86;
      default: hex_glyph = 8'h8E;
    endcase
  endfunction

  logic [9:0]        word_off;
  logic              wr_en;
  logic [31:0]       timer_rd;
  logic              unused_addr_lsb;

  logic [31:0]       disp_q,    disp_d;
  logic [23:0]       led_q,     led_d;
  logic [23:0]       sync1_q,   sync1_d;
  logic [23:0]       sync2_q,   sync2_d;
  logic [23:0]       cand_q,    cand_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [23:0]       sw_db_q,   sw_db_d;
  logic [SCAN_W-1:0] scan_q,    scan_d;
  logic [2:0]        idx_q,     idx_d;
  logic [7:0]        seg_an_q,  seg_an_d;
  logic [7:0]        seg_ca_q,  seg_ca_d;

  assign hit_o           = (addr_i[31:12] == BASE_ADDR[31:12]);
  assign word_off        = addr_i[11:2];
  assign wr_en           = we_i && hit_o;
  assign unused_addr_lsb = &{1'b0, addr_i[1:0]};

`ifdef IO_TIMER_EN
  localparam int TDIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [TDIV_W-1:0] C_TDIV_LAST = TDIV_W'(TIMER_DIV - 1);

  logic [31:0]       timer_q, timer_d;
  logic [TDIV_W-1:0] presc_q, presc_d;

  // Timer: a bus write reloads the count and restarts the prescaler, beating a tick
  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q;
    if (wr_en && (word_off == C_OFF_TIMER)) begin
      timer_d = wdata_i;
      presc_d = '0;
    end else if (presc_q == C_TDIV_LAST) begin
      timer_d = timer_q + 32'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
      presc_q <= '0;
    end else begin
      timer_q <= timer_d;
      presc_q <= presc_d;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = 32'h0;
`endif

  // Writable registers: DISP and LED
  always_comb begin
    disp_d = disp_q;
    led_d  = led_q;
    if (wr_en) begin
      case (word_off)
        C_OFF_DISP: disp_d = wdata_i;
        C_OFF_LED:  led_d  = wdata_i[23:0];
        default: ;
      endcase
    end
  end

  // Switch path: two-flop sync, then one shared stability counter that saturates
  always_comb begin
    sync1_d   = sw_i;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    sw_db_d   = sw_db_q;
    if (sync2_q != cand_q) begin
      cand_d    = sync2_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q == C_DEB_LAST) begin
      sw_db_d = cand_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Display scan; outputs follow the next index and next DISP so the glyph tracks writes
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (scan_q == C_SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end else begin
      scan_d = scan_q + 1'b1;
    end
    seg_an_d = ~(8'd1 << idx_d);
    seg_ca_d = hex_glyph(disp_d[{idx_d, 2'b00} +: 4]);
  end

  // Zero-latency read mux; anything outside the window or unmapped reads zero
  always_comb begin
    rdata_o = 32'h0;
    if (hit_o) begin
      case (word_off)
        C_OFF_DISP:  rdata_o = disp_q;
        C_OFF_TIMER: rdata_o = timer_rd;
        C_OFF_LED:   rdata_o = {8'h0, led_q};
        C_OFF_SW:    rdata_o = {8'h0, sw_db_q};
        default:     rdata_o = 32'h0;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      disp_q    <= '0;
      led_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      deb_cnt_q <= '0;
      sw_db_q   <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      seg_an_q  <= 8'hFE;
      seg_ca_q  <= 8'hC0;
    end else begin
      disp_q    <= disp_d;
      led_q     <= led_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      deb_cnt_q <= deb_cnt_d;
      sw_db_q   <= sw_db_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      seg_an_q  <= seg_an_d;
      seg_ca_q  <= seg_ca_d;
    end
  end

  assign led_o    = led_q;
  assign seg_an_o = seg_an_q;
  assign seg_ca_o = seg_ca_q;

endmodule
`default_nettype wire
